// File: rtl/inst_queue_pkg.sv
// Shared decode definitions: index-width helper, boolean type and the packed
// decoded-instruction record that the instruction queue stores per entry.
`ifndef IDX_LEN
`define IDX_LEN(n) $clog2(n)
`endif

package inst_queue_pkg;

    typedef logic bool_t;

    typedef enum logic [3:0] {
        OP_ALU    = 4'd0,
        OP_MUL    = 4'd1,
        OP_LOAD   = 4'd2,
        OP_STORE  = 4'd3,
        OP_BRANCH = 4'd4,
        OP_JUMP   = 4'd5,
        OP_SYS    = 4'd6
    } op_class_e;

    // Field widths sum to exactly 64 bits, the default payload width.
    typedef struct packed {
        op_class_e   op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [11:0] pc_off;
        bool_t       uses_imm;
    } dec_inst_t;

    localparam int DEC_W = $bits(dec_inst_t);

endpackage

// File: rtl/inst_queue_lead_ones.sv
// Counts the unbroken run of ones starting at bit 0; used to turn per-lane
// handshakes into an in-order enqueue or dequeue count.
module lead_ones #(
    parameter int W = 4
) (
    input  logic [W-1:0]             valid_bits,
    output logic [$clog2(W+1)-1:0]   ones
);

    localparam int OW = $clog2(W + 1);

    logic run;

    always_comb begin
        ones = '0;
        run  = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (run && valid_bits[i]) begin
                ones = OW'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Multi-lane circular instruction queue between decode and dispatch:
// IN_W in-order enqueue lanes, OUT_W in-order dequeue lanes, flush on redirect.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int IN_W   = 4,
    parameter int OUT_W  = 2,
    parameter int DATA_W = DEC_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [IN_W-1:0]               in_valid,
    input  logic [IN_W*DATA_W-1:0]        in_data,
    output logic [IN_W-1:0]               in_avail,
    output logic [OUT_W-1:0]              out_valid,
    output logic [OUT_W*DATA_W-1:0]       out_data,
    input  logic [OUT_W-1:0]              out_ready,
    output logic [$clog2(SIZE+1)-1:0]     count
);

    localparam int IDX_W = `IDX_LEN(SIZE);
    localparam int CNT_W = $clog2(SIZE + 1);
    localparam int EW    = $clog2(IN_W + 1);
    localparam int DW    = $clog2(OUT_W + 1);

    if (SIZE < 2 || SIZE > 256 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
        $error("inst_queue: SIZE must be a power of two in 2..256");
    end
    if (IN_W < 1 || IN_W > SIZE) begin : g_bad_in_w
        $error("inst_queue: IN_W must be in 1..SIZE");
    end
    if (OUT_W < 1 || OUT_W > SIZE) begin : g_bad_out_w
        $error("inst_queue: OUT_W must be in 1..SIZE");
    end

    logic [DATA_W-1:0] mem [SIZE];
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;
    logic [CNT_W-1:0]  count_next;
    logic [IDX_W-1:0]  head_next;
    logic [IDX_W-1:0]  tail_next;
    logic [IN_W-1:0]   enq_ok;
    logic [OUT_W-1:0]  deq_ok;
    logic [EW-1:0]     enq_n;
    logic [DW-1:0]     deq_n;
    bool_t             clear;

    // Availability looks only at registered occupancy, so a dequeue in the
    // same cycle never frees a slot for this cycle's enqueue.
    always_comb begin
        in_avail = '0;
        for (int i = 0; i < IN_W; i++) begin
            in_avail[i] = (SIZE - int'(count)) > i;
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            out_valid[i]                   = int'(count) > i;
            out_data[i*DATA_W +: DATA_W]   = mem[head + IDX_W'(i)];
        end
    end

    assign enq_ok = in_valid & in_avail;
    assign deq_ok = out_valid & out_ready;

    lead_ones #(.W(IN_W)) u_enq_count (
        .valid_bits (enq_ok),
        .ones       (enq_n)
    );

    lead_ones #(.W(OUT_W)) u_deq_count (
        .valid_bits (deq_ok),
        .ones       (deq_n)
    );

    assign clear      = reset | flush;
    assign count_next = count + CNT_W'(enq_n) - CNT_W'(deq_n);
    assign head_next  = head + IDX_W'(deq_n);
    assign tail_next  = tail + IDX_W'(enq_n);

    always_ff @(posedge clock) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        for (int k = 0; k < IN_W; k++) begin
            if (!clear && (k < int'(enq_n))) begin
                mem[tail + IDX_W'(k)] <= in_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed vector table, a wrap-around
// sequence and randomized traffic compared against a queue-based model.
module tb_inst_queue;

    localparam int SIZE   = 16;
    localparam int IN_W   = 4;
    localparam int OUT_W  = 2;
    localparam int DATA_W = 64;
    localparam int CNT_W  = $clog2(SIZE + 1);

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      flush;
    logic [IN_W-1:0]           in_valid;
    logic [IN_W*DATA_W-1:0]    in_data;
    logic [IN_W-1:0]           in_avail;
    logic [OUT_W-1:0]          out_valid;
    logic [OUT_W*DATA_W-1:0]   out_data;
    logic [OUT_W-1:0]          out_ready;
    logic [CNT_W-1:0]          count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] model_q[$];

    typedef struct {
        logic        rst;
        logic        fl;
        logic [3:0]  iv;
        logic [1:0]  ordy;
        int          base;
        int          exp_count;
        logic [3:0]  exp_avail;
        logic [1:0]  exp_valid;
        logic [63:0] exp_d0;
        logic [63:0] exp_d1;
    } vec_t;

    vec_t vecs[19];

    inst_queue #(
        .SIZE   (SIZE),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_avail  (in_avail),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compares the current outputs with what the model's queue contents imply.
    task automatic check_output();
        int sz;
        logic [IN_W-1:0]  exp_avail;
        logic [OUT_W-1:0] exp_valid;
        sz = model_q.size();
        for (int i = 0; i < IN_W; i++) exp_avail[i] = (SIZE - sz) > i;
        for (int i = 0; i < OUT_W; i++) exp_valid[i] = sz > i;
        check_val("model count", DATA_W'(count), DATA_W'(sz));
        check_val("model in_avail", DATA_W'(in_avail), DATA_W'(exp_avail));
        check_val("model out_valid", DATA_W'(out_valid), DATA_W'(exp_valid));
        for (int i = 0; i < OUT_W; i++) begin
            if (i < sz) check_val("model out_data", out_data[i*DATA_W +: DATA_W], model_q[i]);
        end
    endtask

    // Called #1 after a posedge; drives one cycle, checks, then advances the model.
    task automatic apply_stimulus(input logic rst, input logic fl, input logic [IN_W-1:0] iv,
                                  input logic [IN_W*DATA_W-1:0] d, input logic [OUT_W-1:0] ordy);
        int sz;
        int e;
        int dq;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #3;
        check_output();
        sz = model_q.size();
        e  = 0;
        while (e < IN_W && iv[e] && (SIZE - sz) > e) e++;
        dq = 0;
        while (dq < OUT_W && dq < sz && ordy[dq]) dq++;
        @(posedge clock);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            repeat (dq) void'(model_q.pop_front());
            for (int k = 0; k < e; k++) model_q.push_back(d[k*DATA_W +: DATA_W]);
        end
        #1;
    endtask

    function automatic logic [IN_W*DATA_W-1:0] lane_data(input int base);
        logic [IN_W*DATA_W-1:0] d;
        for (int k = 0; k < IN_W; k++) d[k*DATA_W +: DATA_W] = DATA_W'(base + k);
        return d;
    endfunction

    initial begin
        logic [IN_W*DATA_W-1:0] d;
        logic [IN_W-1:0]        iv;
        logic [OUT_W-1:0]       ordy;
        logic                   rst;
        logic                   fl;

        //            rst fl  iv       ordy   base cnt avail    valid  d0  d1
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 2'b00, 0,   0,  4'b1111, 2'b00, 0,  0};
        vecs[1]  = '{1'b0, 1'b0, 4'b1111, 2'b00, 1,   4,  4'b1111, 2'b11, 1,  2};
        vecs[2]  = '{1'b1, 1'b0, 4'b0000, 2'b00, 0,   0,  4'b1111, 2'b00, 0,  0};
        vecs[3]  = '{1'b0, 1'b0, 4'b1011, 2'b00, 10,  2,  4'b1111, 2'b11, 10, 11};
        vecs[4]  = '{1'b0, 1'b0, 4'b1111, 2'b00, 20,  6,  4'b1111, 2'b11, 10, 11};
        vecs[5]  = '{1'b0, 1'b0, 4'b1111, 2'b00, 30,  10, 4'b1111, 2'b11, 10, 11};
        vecs[6]  = '{1'b0, 1'b0, 4'b1111, 2'b00, 40,  14, 4'b0011, 2'b11, 10, 11};
        vecs[7]  = '{1'b0, 1'b0, 4'b1111, 2'b11, 50,  14, 4'b0011, 2'b11, 20, 21};
        vecs[8]  = '{1'b0, 1'b0, 4'b1111, 2'b00, 60,  16, 4'b0000, 2'b11, 20, 21};
        vecs[9]  = '{1'b0, 1'b0, 4'b1111, 2'b01, 70,  15, 4'b0001, 2'b11, 21, 22};
        vecs[10] = '{1'b0, 1'b0, 4'b0000, 2'b10, 0,   15, 4'b0001, 2'b11, 21, 22};
        vecs[11] = '{1'b0, 1'b1, 4'b1111, 2'b11, 90,  0,  4'b1111, 2'b00, 0,  0};
        vecs[12] = '{1'b0, 1'b0, 4'b1111, 2'b00, 70,  4,  4'b1111, 2'b11, 70, 71};
        vecs[13] = '{1'b0, 1'b0, 4'b1111, 2'b00, 74,  8,  4'b1111, 2'b11, 70, 71};
        vecs[14] = '{1'b0, 1'b0, 4'b0001, 2'b00, 80,  9,  4'b1111, 2'b11, 70, 71};
        vecs[15] = '{1'b0, 1'b1, 4'b1111, 2'b11, 100, 0,  4'b1111, 2'b00, 0,  0};
        vecs[16] = '{1'b0, 1'b0, 4'b1111, 2'b00, 90,  4,  4'b1111, 2'b11, 90, 91};
        vecs[17] = '{1'b1, 1'b1, 4'b1111, 2'b11, 110, 0,  4'b1111, 2'b00, 0,  0};
        vecs[18] = '{1'b0, 1'b0, 4'b0001, 2'b00, 5,   1,  4'b1111, 2'b01, 5,  0};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        @(posedge clock);
        #1;
        model_q.delete();

        for (int v = 0; v < 19; v++) begin
            apply_stimulus(vecs[v].rst, vecs[v].fl, vecs[v].iv, lane_data(vecs[v].base), vecs[v].ordy);
            check_val($sformatf("vec%0d count", v), DATA_W'(count), DATA_W'(vecs[v].exp_count));
            check_val($sformatf("vec%0d in_avail", v), DATA_W'(in_avail), DATA_W'(vecs[v].exp_avail));
            check_val($sformatf("vec%0d out_valid", v), DATA_W'(out_valid), DATA_W'(vecs[v].exp_valid));
            if (vecs[v].exp_valid[0])
                check_val($sformatf("vec%0d out_data0", v), out_data[0 +: DATA_W], vecs[v].exp_d0);
            if (vecs[v].exp_valid[1])
                check_val($sformatf("vec%0d out_data1", v), out_data[DATA_W +: DATA_W], vecs[v].exp_d1);
        end

        // Wrap: park head and tail at slot 14, then enqueue across the boundary.
        apply_stimulus(1'b1, 1'b0, '0, '0, '0);
        for (int c = 0; c < 3; c++) apply_stimulus(1'b0, 1'b0, 4'b1111, lane_data(200 + 4*c), 2'b00);
        apply_stimulus(1'b0, 1'b0, 4'b0011, lane_data(220), 2'b00);
        for (int c = 0; c < 7; c++) apply_stimulus(1'b0, 1'b0, 4'b0000, '0, 2'b11);
        check_val("wrap drained count", DATA_W'(count), 0);
        apply_stimulus(1'b0, 1'b0, 4'b1111, lane_data('hA0), 2'b00);
        check_val("wrap count", DATA_W'(count), 4);
        check_val("wrap slot14", out_data[0 +: DATA_W], 'hA0);
        check_val("wrap slot15", out_data[DATA_W +: DATA_W], 'hA1);
        apply_stimulus(1'b0, 1'b0, 4'b0000, '0, 2'b11);
        check_val("wrap count after deq", DATA_W'(count), 2);
        check_val("wrap slot0", out_data[0 +: DATA_W], 'hA2);
        check_val("wrap slot1", out_data[DATA_W +: DATA_W], 'hA3);

        // Randomized traffic; the first half of each window leans toward filling.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(99) == 0);
            fl  = ($urandom_range(49) == 0);
            iv  = IN_W'($urandom);
            if ((c % 200) < 100) ordy = OUT_W'($urandom & $urandom & $urandom);
            else                 ordy = OUT_W'($urandom);
            for (int k = 0; k < IN_W; k++) d[k*DATA_W +: DATA_W] = {$urandom, $urandom};
            apply_stimulus(rst, fl, iv, d, ordy);
        end
        check_output();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter SIZE, default 16, queue depth in entries; SHALL be a power of two, 2..256.
REQ-002 Parameter IN_W, default 4, enqueue lanes per cycle; 1 <= IN_W <= SIZE.
REQ-003 Parameter OUT_W, default 2, dequeue lanes per cycle; 1 <= OUT_W <= SIZE.
REQ-004 Parameter DATA_W, default 64, payload bits per entry (packed decoded instruction).
REQ-005 clock  input  1  clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  mispredict/exception flush; discards all entries.
REQ-008 in_valid  input  IN_W  enqueue request per lane.
REQ-009 in_data  input  IN_W x DATA_W  enqueue payload per lane.
REQ-010 in_avail  output  IN_W  lane i may enqueue this cycle.
REQ-011 out_valid  output  OUT_W  lane i holds a valid entry.
REQ-012 out_data  output  OUT_W x DATA_W  payload of entry head+i.
REQ-013 out_ready  input  OUT_W  consumer accepts lane i.
REQ-014 count  output  clog2(SIZE+1)  registered occupancy.

Function
REQ-015 Storage SHALL be a circular buffer with registered head, tail, count; indices wrap modulo SIZE.
REQ-016 in_avail[i] SHALL equal (SIZE - count) > i, from registered count only; same-cycle dequeues SHALL NOT raise availability.
REQ-017 Enqueue count E SHALL be the length of the leading prefix of lanes with in_valid[i] && in_avail[i]; lanes after the first failing lane SHALL be dropped even if valid.
REQ-018 Lane k < E SHALL write in_data[k] to slot (tail+k) mod SIZE; tail advances by E.
REQ-019 out_valid[i] SHALL equal count > i; out_data[i] SHALL be slot (head+i) mod SIZE, combinational from storage; invalid lanes' data is don't-care.
REQ-020 Dequeue count D SHALL be the leading-prefix length of lanes with out_valid[i] && out_ready[i]; head advances by D.
REQ-021 count_next SHALL be count + E - D; enqueue and dequeue in the same cycle SHALL both take effect.
REQ-022 Enqueue-to-visible latency SHALL be one cycle; no write-to-read bypass.
REQ-023 Full (count == SIZE): all in_avail low; empty (count == 0): all out_valid low.
REQ-024 flush SHALL, next cycle, set head = tail = count = 0 and take priority over any same-cycle enqueue or dequeue; storage contents need not be cleared.
REQ-025 Head/tail arithmetic SHALL use clog2(SIZE) bits with natural wrap; count SHALL never exceed SIZE.

Reset
REQ-026 reset SHALL have priority over flush and set head = tail = count = 0.
REQ-027 After reset: out_valid = 0, in_avail = all ones (given IN_W <= SIZE), count = 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight enqueues and dequeues of that cycle.

Structure
REQ-029 IDX_LEN macro, bool type, and the decoded-instruction entry struct (width = DATA_W) SHALL live in the shared decode package.
REQ-030 One sub-module, lead_ones (parametrised width, outputs count of leading ones), SHALL compute E and D.
REQ-031 Storage SHALL be a flop array; no SRAM macro.

Verification
REQ-032 Reset, then in_valid = 4'b1111, data 1..4 -> next cycle count = 4, out_data[0..1] = 1,2, out_valid = 2'b11.
REQ-033 in_valid = 4'b1011 at count 0 -> only lane 0 and lane 1 enqueued; count = 2.
REQ-034 count = 14 (SIZE 16), in_valid = 4'b1111, out_ready = 2'b11 -> in_avail = 4'b0011, E = 2, D = 2, count stays 14.
REQ-035 Fill past slot 15 with head at 14 -> out_data[0..1] read slots 14 and 15, then 0 and 1 after wrap, in order.
REQ-036 flush with count = 9 and in_valid = 4'b1111 -> next cycle count = 0, out_valid = 0; reset and flush together -> same result.
